// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared 64b/66b block constants and sync-header check
package gearbox_pkg;

   localparam int         BLOCK_W   = 66;
   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // Only the two transition patterns are legal sync headers; 00 and 11 are not.
   function automatic logic hdr_valid(input logic [1:0] sync_hdr);
      return (sync_hdr == SYNC_DATA) || (sync_hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/gb_bit_accum.sv
// rtl/gb_bit_accum.sv - bit accumulator with block extraction and single-bit drop
module gb_bit_accum #(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 66
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               data_valid_i,
   input  logic               drop_i,
   output logic [BLOCK_W-1:0] block_o,
   output logic               emit_o,
   output logic               dropped_o
);

   // Holds up to BLOCK_W-1 leftover bits plus one fresh word. The oldest bit sits at the MSB;
   // the valid bits are the top fill_q bits and everything below them is kept at zero.
   localparam int ACC_W  = BLOCK_W + DATA_W - 1;
   localparam int FILL_W = ($clog2(ACC_W + 1) < 7) ? 7 : $clog2(ACC_W + 1);

   localparam logic [FILL_W-1:0] BLOCK_F = FILL_W'(BLOCK_W);
   localparam logic [FILL_W-1:0] DATA_F  = FILL_W'(DATA_W);
   localparam logic [FILL_W-1:0] TOP_F   = FILL_W'(ACC_W - DATA_W);
   localparam logic [FILL_W-1:0] ONE_F   = FILL_W'(1);

   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_app;
   logic [ACC_W-1:0]  acc_emit;
   logic [ACC_W-1:0]  acc_nxt;
   logic [ACC_W-1:0]  data_ext;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_app;
   logic [FILL_W-1:0] fill_emit;
   logic [FILL_W-1:0] fill_nxt;

   assign data_ext = {{(ACC_W - DATA_W){1'b0}}, data_i};

   // Append, then extract a block, then drop one bit: the drop always sees the post-emission
   // alignment so it can never remove a bit belonging to the block leaving this cycle.
   always_comb begin
      acc_app  = acc_q;
      fill_app = fill_q;
      if (data_valid_i) begin
         acc_app  = acc_q | (data_ext << (TOP_F - fill_q));
         fill_app = fill_q + DATA_F;
      end

      emit_o    = data_valid_i && (fill_app >= BLOCK_F);
      block_o   = acc_app[ACC_W-1 -: BLOCK_W];
      acc_emit  = acc_app;
      fill_emit = fill_app;
      if (emit_o) begin
         acc_emit  = acc_app << BLOCK_W;
         fill_emit = fill_app - BLOCK_F;
      end

      dropped_o = drop_i && (fill_emit != '0);
      acc_nxt   = acc_emit;
      fill_nxt  = fill_emit;
      if (dropped_o) begin
         acc_nxt  = acc_emit << 1;
         fill_nxt = fill_emit - ONE_F;
      end
   end

   // Accumulator state; reset discards any partial block.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         fill_q <= '0;
      end else begin
         acc_q  <= acc_nxt;
         fill_q <= fill_nxt;
      end
   end

endmodule

// File: rtl/rx_gearbox_66b_param.sv
// rtl/rx_gearbox_66b_param.sv - DATA_W-bit RX words to 66-bit blocks with bit-slip control
module rx_gearbox_66b_param
   import gearbox_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int SLIP_HOLDOFF = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_valid_i,
   input  logic              slip_i,
   output logic [65:0]       block_o,
   output logic              block_valid_o,
   output logic              hdr_ok_o,
   output logic              slip_busy_o
);

   localparam int                HOLD_W    = $clog2(SLIP_HOLDOFF + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SLIP_HOLDOFF);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   logic               slip_q;
   logic               slip_pend;
   logic               slip_edge;
   logic [HOLD_W-1:0]  holdoff;
   logic [BLOCK_W-1:0] acc_block;
   logic               acc_emit;
   logic               acc_dropped;

   gb_bit_accum #(
      .DATA_W  (DATA_W),
      .BLOCK_W (BLOCK_W)
   ) u_accum (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .drop_i       (slip_pend),
      .block_o      (acc_block),
      .emit_o       (acc_emit),
      .dropped_o    (acc_dropped)
   );

   assign slip_edge   = slip_i & ~slip_q;
   assign slip_busy_o = slip_pend | (holdoff != '0);

   // Output registers plus slip bookkeeping. Edges seen while busy are dropped, not queued;
   // the holdoff counts only blocks leaving after the slip, so the block emitted in the
   // same cycle as the drop (still pre-slip aligned) is not counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         block_o       <= '0;
         block_valid_o <= 1'b0;
         hdr_ok_o      <= 1'b0;
         slip_q        <= 1'b0;
         slip_pend     <= 1'b0;
         holdoff       <= '0;
      end else begin
         slip_q        <= slip_i;
         block_valid_o <= acc_emit;
         if (acc_emit) begin
            block_o  <= acc_block;
            hdr_ok_o <= hdr_valid(acc_block[BLOCK_W-1 -: 2]);
         end

         if (acc_dropped) begin
            slip_pend <= 1'b0;
            holdoff   <= HOLD_INIT;
         end else begin
            if (slip_edge && !slip_busy_o) begin
               slip_pend <= 1'b1;
            end
            if (acc_emit && (holdoff != '0)) begin
               holdoff <= holdoff - HOLD_ONE;
            end
         end
      end
   end

endmodule
